// File: rtl/simple_stream_pkg.sv
// rtl/simple_stream_pkg.sv - shared widths and count-width helper for the simple stream blocks
package simple_stream_pkg;

  localparam int DefaultDataWidth = 64;
  localparam int DefaultElemWidth = 8;

  // Element-count width: must be able to hold the value num_elems itself.
  function automatic int cnt_width(input int num_elems);
    return $clog2(num_elems + 1);
  endfunction

endpackage

// File: rtl/simple_packer_if.sv
// rtl/simple_packer_if.sv - element-in / word-out handshake bundle of simple_packer
interface simple_packer_if
  import simple_stream_pkg::*;
#(
  parameter int DataWidth = DefaultDataWidth,
  parameter int ElemWidth = DefaultElemWidth
) ();

  localparam int NumElems = DataWidth / ElemWidth;
  localparam int CntWidth = cnt_width(NumElems);

  logic [ElemWidth-1:0] data_i;
  logic                 data_valid_i;
  logic                 data_last_i;
  logic                 data_ready_o;
  logic [DataWidth-1:0] data_o;
  logic [CntWidth-1:0]  data_cnt_o;
  logic                 data_valid_o;
  logic                 data_ready_i;

  modport slave (
    input  data_i, data_valid_i, data_last_i, data_ready_i,
    output data_ready_o, data_o, data_cnt_o, data_valid_o
  );

  modport master (
    output data_i, data_valid_i, data_last_i, data_ready_i,
    input  data_ready_o, data_o, data_cnt_o, data_valid_o
  );

endinterface

// File: rtl/simple_stream_reg.sv
// rtl/simple_stream_reg.sv - single-entry valid/ready output register carrying data plus count
module simple_stream_reg #(
  parameter int DataWidth = 64,
  parameter int CntWidth  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [CntWidth-1:0]  cnt_i,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic [CntWidth-1:0]  cnt_o,
  output logic                 valid_o,
  output logic                 free_o
);

  logic [DataWidth-1:0] data_q, data_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 valid_q, valid_d;

  assign free_o  = !valid_q || ready_i;
  assign data_o  = data_q;
  assign cnt_o   = cnt_q;
  assign valid_o = valid_q;

  // load_i is only raised while free_o is high, so a load may replace a word being taken.
  always_comb begin
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      cnt_d   = cnt_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      data_d  = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/simple_packer.sv
// rtl/simple_packer.sv - packs narrow elements little-endian into wide words with early close on last
module simple_packer
  import simple_stream_pkg::*;
#(
  parameter int DataWidth = DefaultDataWidth,
  parameter int ElemWidth = DefaultElemWidth
) (
  input logic             clk_i,
  input logic             rst_ni,
  simple_packer_if.slave  bus
);

  localparam int NumElems = DataWidth / ElemWidth;
  localparam int CntWidth = cnt_width(NumElems);
  localparam logic [CntWidth-1:0] LastSlot = CntWidth'(NumElems - 1);

  logic [DataWidth-1:0] acc_q, acc_d, acc_wr;
  logic [CntWidth-1:0]  cnt_q, cnt_d, cnt_inc;
  logic                 acc_full_q, acc_full_d;
  logic                 accept, completes, out_free;
  logic                 load;
  logic [DataWidth-1:0] load_data;
  logic [CntWidth-1:0]  load_cnt;

  assign bus.data_ready_o = !acc_full_q;
  assign accept    = bus.data_valid_i && !acc_full_q;
  assign completes = (cnt_q == LastSlot) || bus.data_last_i;
  assign cnt_inc   = cnt_q + CntWidth'(1);
  // Unwritten slots are already zero, so OR-ing the shifted element in is a slot write.
  assign acc_wr    = acc_q | (DataWidth'(bus.data_i) << (int'(cnt_q) * ElemWidth));

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    acc_full_d = acc_full_q;
    load       = 1'b0;
    load_data  = acc_wr;
    load_cnt   = cnt_inc;
    if (acc_full_q) begin
      load_data = acc_q;
      load_cnt  = cnt_q;
      if (out_free) begin
        load       = 1'b1;
        acc_d      = '0;
        cnt_d      = '0;
        acc_full_d = 1'b0;
      end
    end else if (accept && completes) begin
      if (out_free) begin
        load  = 1'b1;
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d      = acc_wr;
        cnt_d      = cnt_inc;
        acc_full_d = 1'b1;
      end
    end else if (accept) begin
      acc_d = acc_wr;
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      acc_full_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      acc_full_q <= acc_full_d;
    end
  end

  simple_stream_reg #(
    .DataWidth (DataWidth),
    .CntWidth  (CntWidth)
  ) u_out_reg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (load),
    .data_i  (load_data),
    .cnt_i   (load_cnt),
    .ready_i (bus.data_ready_i),
    .data_o  (bus.data_o),
    .cnt_o   (bus.data_cnt_o),
    .valid_o (bus.data_valid_o),
    .free_o  (out_free)
  );

endmodule

// File: tb/tb_simple_packer.sv
// tb/tb_simple_packer.sv - scoreboard bench for simple_packer with directed and random traffic
module tb_simple_packer;

  localparam int NE = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  bit   rand_mode = 1'b0;

  logic [7:0]  cur_q[$];
  logic [63:0] exp_data_q[$];
  logic [3:0]  exp_cnt_q[$];

  simple_packer_if bus ();

  simple_packer dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: gather accepted elements; a word closes on the NE-th element or on last.
  task automatic model_accept(input logic [7:0] d, input logic last);
    logic [63:0] w;
    cur_q.push_back(d);
    if (cur_q.size() == NE || last) begin
      w = '0;
      foreach (cur_q[i]) w[i*8 +: 8] = cur_q[i];
      exp_data_q.push_back(w);
      exp_cnt_q.push_back(4'(cur_q.size()));
      cur_q.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) bus.data_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.data_valid_i = 1'b0;
      bus.data_last_i  = $urandom_range(0, 1);
      bus.data_i       = 8'($urandom);
      tick();
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last, output int waits);
    bit done;
    bus.data_i       = d;
    bus.data_valid_i = 1'b1;
    bus.data_last_i  = last;
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.data_ready_o) begin
        model_accept(d, last);
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 200) begin
          tests++;
          fails++;
          $display("FAIL send_timeout: element %h not accepted within 200 cycles", d);
          done = 1'b1;
        end
      end
      tick();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(bus.data_ready_o), 64'd1);
    chk({tag, "_valid"}, 64'(bus.data_valid_o), 64'd0);
    chk({tag, "_data"},  bus.data_o,            64'd0);
    chk({tag, "_cnt"},   64'(bus.data_cnt_o),   64'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    cur_q.delete();
    exp_data_q.delete();
    exp_cnt_q.delete();
    bus.data_valid_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Monitor: pops on each output handshake and checks hold stability during stalls.
  logic [63:0] prev_data;
  logic [3:0]  prev_cnt;
  bit          prev_stall = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.data_valid_o), 64'd1);
        chk("stall_data",  bus.data_o,            prev_data);
        chk("stall_cnt",   64'(bus.data_cnt_o),   64'(prev_cnt));
      end
      if (bus.data_valid_o && bus.data_ready_i) begin
        if (exp_data_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h cnt %0d expected none", bus.data_o, bus.data_cnt_o);
        end else begin
          chk("word_data", bus.data_o, exp_data_q.pop_front());
          chk("word_cnt",  64'(bus.data_cnt_o), 64'(exp_cnt_q.pop_front()));
        end
      end
      prev_stall = bus.data_valid_o && !bus.data_ready_i;
      prev_data  = bus.data_o;
      prev_cnt   = bus.data_cnt_o;
    end
  end

  task automatic drain(input string tag);
    int n = 0;
    while (exp_data_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, 64'(exp_data_q.size()), 64'd0);
  endtask

  initial begin
    int w;
    int tw;
    bus.data_i       = '0;
    bus.data_valid_i = 1'b0;
    bus.data_last_i  = 1'b0;
    bus.data_ready_i = 1'b1;
    #1;
    check_reset_outputs("in_reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Single full word, no input stall, valid one cycle after last accept.
    tw = 0;
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), 1'b0, w);
      tw += w;
    end
    chk("t1_valid_latency", 64'(bus.data_valid_o), 64'd1);
    chk("t1_no_stall", 64'(tw), 64'd0);
    idle(2);
    drain("t1");

    // Back-to-back two words.
    tw = 0;
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b0, w);
      tw += w;
    end
    chk("t2_no_bubbles", 64'(tw), 64'd0);
    idle(2);
    drain("t2");

    // Early close with last, then next word starts at slot 0.
    send(8'hAA, 1'b0, w);
    send(8'hBB, 1'b0, w);
    send(8'hCC, 1'b1, w);
    for (int i = 0; i < 8; i++) send(8'h11 + 8'(i), 1'b0, w);
    idle(2);
    drain("t3");

    // Full-buffer stall, release, one bubble.
    bus.data_ready_i = 1'b0;
    tw = 0;
    for (int i = 0; i < 16; i++) begin
      send(8'h20 + 8'(i), 1'b0, w);
      tw += w;
    end
    chk("t4_fill_no_wait", 64'(tw), 64'd0);
    chk("t4_ready_low", 64'(bus.data_ready_o), 64'd0);
    bus.data_i       = 8'h40;
    bus.data_valid_i = 1'b1;
    bus.data_last_i  = 1'b1;
    tick();
    tick();
    chk("t4_still_blocked", 64'(bus.data_ready_o), 64'd0);
    bus.data_ready_i = 1'b1;
    send(8'h40, 1'b1, w);
    chk("t4_one_bubble", 64'(w), 64'd1);
    idle(2);
    drain("t4");

    // Reset mid-word and mid-stall.
    for (int i = 0; i < 5; i++) send(8'h50 + 8'(i), 1'b0, w);
    apply_reset();
    bus.data_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) send(8'h60 + 8'(i), 1'b0, w);
    apply_reset();
    bus.data_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) send(8'h71 + 8'(i), 1'b0, w);
    idle(2);
    drain("t5");

    // Randomized traffic.
    rand_mode = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send(8'($urandom), ($urandom_range(0, 5) == 0), w);
    end
    send(8'hEE, 1'b1, w);
    bus.data_valid_i = 1'b0;
    rand_mode = 1'b0;
    bus.data_ready_i = 1'b1;
    tick();
    drain("rand");
    chk("rand_no_partial", 64'(cur_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/simple_packer.md
# simple_packer

Stream width adapter upstream of the simple reshuffler: accepts narrow `ElemWidth` elements on a valid/ready stream and packs `DataWidth/ElemWidth` consecutive elements, little-endian, into one `DataWidth` word. Its output port feeds the reshuffler's `data_i`/`data_valid_i`/`data_ready_o` directly. A `data_last_i` marker closes a partial word early, zero-padded, with a count of valid elements. An accumulator plus an output register give full throughput when downstream is ready and hold one completed word while downstream stalls.

## Interface
- `DataWidth`, 64, output word width; must be a multiple of `ElemWidth`.
- `ElemWidth`, 8, input element width.
- `NumElems`, `DataWidth/ElemWidth` (derived, not overridden), elements per word; must be ≥ 2.
- `CntWidth`, `$clog2(NumElems+1)` (derived), width of the element count.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `data_i`  in  `ElemWidth`  input element.
- `data_valid_i`  in  1  input element valid.
- `data_last_i`  in  1  qualifies `data_i`; this element ends the current word.
- `data_ready_o`  out  1  packer accepts an element this cycle.
- `data_o`  out  `DataWidth`  packed word; element k at bits `[k*ElemWidth +: ElemWidth]`.
- `data_cnt_o`  out  `CntWidth`  number of valid elements in `data_o` (1..`NumElems`).
- `data_valid_o`  out  1  packed word valid.
- `data_ready_i`  in  1  downstream accepts word.

## Operation
- Input handshake: an element is accepted when `data_valid_i && data_ready_o`. Output handshake: a word is taken when `data_valid_o && data_ready_i`.
- Accumulator state:
  - `acc_q`: `DataWidth` bits, zero when empty.
  - `cnt_q`: `CntWidth` bits, number of elements collected.
  - `acc_full_q`: a completed word is waiting for the output register.
- `data_ready_o = !acc_full_q` (combinational).
- An accepted element is written at slot `cnt_q`, and `cnt_q` increments.
- The element completes the word when `cnt_q == NumElems-1` or `data_last_i` is high.
- Output register is free in a cycle when `!data_valid_o || data_ready_i`.
- When a completing element is accepted:
  - If the output register is free, the word (including that element) loads directly into the output register with count `cnt_q+1`. The accumulator clears to zero and `cnt_q` to 0.
  - Otherwise the word is held in the accumulator and `acc_full_q` is set.
- While `acc_full_q` is set and the output register is free, the accumulator word moves to the output register. The accumulator then clears, and `acc_full_q` clears.
- On an output handshake with no reload, `data_o` clears to 0, `data_cnt_o` to 0 and `data_valid_o` to 0.
- Slots that were never written read as zero (padding).
- `data_last_i` on an element that also fills slot `NumElems-1` gives an ordinary full word (count `NumElems`).
- `data_last_i` is ignored when `data_valid_i` is low.
- `data_i` is ignored unless the input handshake occurs.

## Timing
- Reset values:
  - `data_ready_o` = 1, including while `rst_ni` is low.
  - `data_valid_o` = 0, `data_o` = 0, `data_cnt_o` = 0.
  - Internally `acc_q` = 0, `cnt_q` = 0, `acc_full_q` = 0.
- Latency: completing element accepted in cycle t with the output register free → `data_valid_o` = 1 in cycle t+1.
- Steady state with `data_ready_i` held high: one element accepted every cycle; one word per `NumElems` cycles, with no bubbles.
- Simultaneous output handshake and reload in the same cycle: the new word replaces the old one; `data_valid_o` stays 1.
- Stall recovery: a held word moves in the cycle the output register frees. `data_ready_o` rises in the next cycle, so one input bubble occurs per stall.
- Downstream stalled indefinitely: one word sits in the output register and one in the accumulator; `data_ready_o` = 0.
- `data_valid_o`, `data_o` and `data_cnt_o` must not change while `data_valid_o && !data_ready_i`.
- Reset asserted mid-word or mid-stall: all state returns to reset values immediately; partial and held words are discarded.

## Structure
- Shared package `simple_stream_pkg` holds:
  - default widths: `DefaultDataWidth`=64, `DefaultElemWidth`=8;
  - the element-count width function.
- One sub-module: `simple_stream_reg`, a single-entry valid/ready output register (data + count, load/clear on handshake), instantiated for the output stage.
- Accumulator and write-slot logic stay in `simple_packer`.

## Test plan
- Reset, then 8 elements 0x01..0x08 with `data_ready_i`=1 → `data_o`=0x0807060504030201, `data_cnt_o`=8; valid 1 cycle after the 8th accept; `data_ready_o` never drops.
- 16 back-to-back elements 0x00..0x0F with `data_ready_i`=1 → two words: 0x0706050403020100, then 0x0F0E0D0C0B0A0908; one word per 8 cycles.
- 3 elements 0xAA, 0xBB, 0xCC with `data_last_i` on 0xCC → `data_o`=0x0000000000CCBBAA, `data_cnt_o`=3; the next element starts at slot 0.
- `data_ready_i`=0, then 16 elements offered → `data_ready_o` falls after the 16th accept, with the 17th held off; `data_o` stays stable. Raise `data_ready_i` → both words delivered in order; one input bubble.
- Assert `rst_ni` low after 5 elements and again during a full-buffer stall → outputs return to reset values at once. A following 8-element burst yields a clean word with no stale bytes.
- Random valid/ready/last stimulus against a scoreboard → no element lost, duplicated or reordered; counts correct; `data_o` stable while stalled.
